slow_clk_monitor: RTL and testbench



---
 rtl/slow_clk_mon_pkg.sv | 32 +++
 rtl/sync_edge_det.sv | 38 +++
 rtl/slow_clk_monitor.sv | 248 ++++++++++++++++++++++++
 tb/tb_slow_clk_monitor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/slow_clk_mon_pkg.sv
// -----------------------------------------------------------------------------
// slow_clk_mon_pkg
// Shared types and constants for the slow clock monitor:
//   state_t   - monitor FSM encoding (IDLE=0, ACQ=1, LOCKED=2, LOST=3)
//   ERR_W     - width of the loss-of-lock event counter
//   AVG_DEPTH - number of periods in the optional moving average
//   sat_inc_err() - saturating increment for the error counter
// -----------------------------------------------------------------------------
package slow_clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_LOST   = 2'd3
    } state_t;

    localparam int ERR_W     = 8;
    localparam int AVG_DEPTH = 4;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] r;
        if (v == {ERR_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(ERR_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous slow strobe into the clk domain through a two-flop
// synchroniser (s1, s2) and flags its rising edge using a delay flop (s3).
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset
//   din  - asynchronous input strobe
//   rise - combinational s2 & ~s3, high for one clk cycle per rising edge
// Pulses shorter than two clk cycles (high or low) may be missed.
// -----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchroniser chain plus one delay stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= din;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/slow_clk_monitor.sv
// -----------------------------------------------------------------------------
// slow_clk_monitor
// Fast-domain receiver for a low-frequency clock/strobe. Measures the period
// between rising edges of mon_in in clk_in cycles, tracks lock against
// EXP_PERIOD +/- TOL and re-emits each edge as a one-cycle strobe.
// Ports:
//   clk_in     - fast system clock
//   rst        - asynchronous active-high reset
//   mon_in     - monitored slow clock (asynchronous)
//   edge_stb   - one-cycle pulse per detected rising edge
//   period_out - last measured period (saturates at 2^CNT_W-1)
//   period_vld - one-cycle pulse when period_out updates (with edge_stb)
//   period_avg - averaged period, or period_out when averaging is not built
//   locked     - high while in LOCKED (one cycle behind the state)
//   lost_stb   - one-cycle pulse on entry to LOST
//   err_cnt    - saturating count of LOCKED->LOST transitions
// Build option: define SLOW_CLK_MON_AVG_EN to build a 4-deep moving average
// on period_avg; otherwise period_avg mirrors period_out.
// -----------------------------------------------------------------------------
module slow_clk_monitor
    import slow_clk_mon_pkg::*;
#(
    parameter int CNT_W      = 10,
    parameter int EXP_PERIOD = 100,
    parameter int TOL        = 2,
    parameter int LOCK_N     = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             mon_in,
    output logic             edge_stb,
    output logic [CNT_W-1:0] period_out,
    output logic             period_vld,
    output logic [CNT_W-1:0] period_avg,
    output logic             locked,
    output logic             lost_stb,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_N + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]    LIM_LO    = (CNT_W+1)'(EXP_PERIOD - TOL);
    localparam logic [CNT_W:0]    LIM_HI    = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0]  TMO_CNT   = CNT_W'(EXP_PERIOD + TOL + 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_N);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

    logic              rise_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              in_tol_s;
    logic              timeout_s;
    logic              meas_s;
    state_t            state_r;
    state_t            state_next;
    state_t            prev_state_r;
    logic [GOOD_W-1:0] good_cnt_r;
    logic [GOOD_W-1:0] good_next;
    logic [GOOD_W-1:0] good_inc_s;
    logic              err_inc_s;

    sync_edge_det u_sync (
        .clk  (clk_in),
        .rst  (rst),
        .din  (mon_in),
        .rise (rise_s)
    );

    // Comparison done one bit wider so the window limits cannot wrap.
    assign in_tol_s   = ({1'b0, cnt_r} >= LIM_LO) && ({1'b0, cnt_r} <= LIM_HI);
    // An edge arriving on the timeout count wins over the timeout.
    assign timeout_s  = (cnt_r == TMO_CNT) && !rise_s;
    // The very first edge after IDLE has no reference and is not a period.
    assign meas_s     = rise_s && (state_r != ST_IDLE);
    assign good_inc_s = good_cnt_r + GOOD_ONE;

    // Period counter: reload to 1 on each edge, saturate at all-ones.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (rise_s) begin
            cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // FSM state and good-period counter registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            prev_state_r <= ST_IDLE;
            good_cnt_r   <= '0;
        end else begin
            state_r      <= state_next;
            prev_state_r <= state_r;
            good_cnt_r   <= good_next;
        end
    end

    // FSM next-state logic, evaluated on an edge or a timeout.
    always_comb begin
        state_next = state_r;
        good_next  = good_cnt_r;
        err_inc_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_next = ST_ACQ;
                    good_next  = '0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ACQ: begin
                if (rise_s) begin
                    if (in_tol_s) begin
                        good_next = good_inc_s;
                        if (good_inc_s == GOOD_LOCK) begin
                            state_next = ST_LOCKED;
                        end else begin
                            state_next = ST_ACQ;
                        end
                    end else begin
                        good_next = '0;
                    end
                end else if (timeout_s) begin
                    state_next = ST_LOST;
                    good_next  = '0;
                end else begin
                    state_next = ST_ACQ;
                end
            end
            ST_LOCKED: begin
                if (rise_s) begin
                    if (in_tol_s) begin
                        state_next = ST_LOCKED;
                    end else begin
                        state_next = ST_LOST;
                        err_inc_s  = 1'b1;
                    end
                end else if (timeout_s) begin
                    state_next = ST_LOST;
                    err_inc_s  = 1'b1;
                end else begin
                    state_next = ST_LOCKED;
                end
            end
            ST_LOST: begin
                if (rise_s) begin
                    state_next = ST_ACQ;
                    good_next  = in_tol_s ? GOOD_ONE : '0;
                end else begin
                    state_next = ST_LOST;
                end
            end
            default: begin
                state_next = ST_IDLE;
                good_next  = '0;
            end
        endcase
    end

    // Registered strobes, measurement and status outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            edge_stb   <= 1'b0;
            period_vld <= 1'b0;
            period_out <= '0;
            locked     <= 1'b0;
            lost_stb   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            edge_stb   <= rise_s;
            period_vld <= meas_s;
            if (meas_s) begin
                period_out <= cnt_r;
            end else begin
                period_out <= period_out;
            end
            locked   <= (state_r == ST_LOCKED);
            // First cycle in LOST only, so a timeout inside LOST stays silent.
            lost_stb <= (state_r == ST_LOST) && (prev_state_r != ST_LOST);
            if (err_inc_s) begin
                err_cnt <= sat_inc_err(err_cnt);
            end else begin
                err_cnt <= err_cnt;
            end
        end
    end

`ifdef SLOW_CLK_MON_AVG_EN
    localparam int FILL_W = $clog2(AVG_DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(AVG_DEPTH);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    logic [CNT_W-1:0]  hist_r [AVG_DEPTH];
    logic [CNT_W+1:0]  sum_r;
    logic [CNT_W+1:0]  sum_next;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_next;
    logic [CNT_W-1:0]  avg_r;

    // Running sum: add the newest period, drop the oldest (zero while filling).
    always_comb begin
        sum_next  = sum_r + {2'b00, period_out} - {2'b00, hist_r[AVG_DEPTH-1]};
        fill_next = (fill_r == FILL_FULL) ? fill_r : (fill_r + FILL_ONE);
    end

    // History and average; held cleared while in IDLE or LOST.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < AVG_DEPTH; i++) begin
                hist_r[i] <= '0;
            end
            sum_r  <= '0;
            fill_r <= '0;
            avg_r  <= '0;
        end else if ((state_r == ST_IDLE) || (state_r == ST_LOST)) begin
            for (int i = 0; i < AVG_DEPTH; i++) begin
                hist_r[i] <= '0;
            end
            sum_r  <= '0;
            fill_r <= '0;
            avg_r  <= '0;
        end else if (period_vld) begin
            hist_r[0] <= period_out;
            for (int i = 1; i < AVG_DEPTH; i++) begin
                hist_r[i] <= hist_r[i-1];
            end
            sum_r  <= sum_next;
            fill_r <= fill_next;
            avg_r  <= (fill_next == FILL_FULL) ? sum_next[CNT_W+1:2] : '0;
        end else begin
            sum_r  <= sum_r;
            fill_r <= fill_r;
            avg_r  <= avg_r;
        end
    end

    assign period_avg = avg_r;
`else
    assign period_avg = period_out;
`endif

endmodule

// File: tb/tb_slow_clk_monitor.sv
// -----------------------------------------------------------------------------
// tb_slow_clk_monitor
// Directed stimulus drives mon_in edge by edge; for each rising edge the
// expected response (period_vld, period_out, locked one cycle later, and
// period_avg) is pushed into a queue, and a monitor pops and compares it when
// the DUT raises edge_stb. Expected lost_stb events are queued as the number
// of cycles after the most recent edge_stb and checked by a second monitor.
// Timing reference: an edge whose rise is seen at posedge P gives edge_stb
// after P+1 (cnt reloads to 1). cnt reaches 103 after P+103, LOST is entered
// at P+104 and lost_stb is visible after P+105: 104 cycles after edge_stb.
// -----------------------------------------------------------------------------
module tb_slow_clk_monitor;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       mon_in;
    logic       edge_stb;
    logic [9:0] period_out;
    logic       period_vld;
    logic [9:0] period_avg;
    logic       locked;
    logic       lost_stb;
    logic [7:0] err_cnt;

    typedef struct {
        bit vld;
        int per;
        bit lk;
        int avg;
    } item_t;

    item_t exp_q[$];
    int    lost_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    always #5 clk_in = ~clk_in;

    slow_clk_monitor #(
        .CNT_W      (10),
        .EXP_PERIOD (100),
        .TOL        (2),
        .LOCK_N     (4)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .mon_in     (mon_in),
        .edge_stb   (edge_stb),
        .period_out (period_out),
        .period_vld (period_vld),
        .period_avg (period_avg),
        .locked     (locked),
        .lost_stb   (lost_stb),
        .err_cnt    (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_edge_stb"},   {31'd0, edge_stb},   32'd0);
        check({tag, "_period_out"}, {22'd0, period_out}, 32'd0);
        check({tag, "_period_vld"}, {31'd0, period_vld}, 32'd0);
        check({tag, "_period_avg"}, {22'd0, period_avg}, 32'd0);
        check({tag, "_locked"},     {31'd0, locked},     32'd0);
        check({tag, "_lost_stb"},   {31'd0, lost_stb},   32'd0);
        check({tag, "_err_cnt"},    {24'd0, err_cnt},    32'd0);
    endtask

    // One rising edge of mon_in followed by 'gap' cycles until the next one.
    // per is the period the DUT must report at this edge (previous gap).
    task automatic ev(input int gap, input bit vld, input int per, input bit lk,
                      input int lostd, input int avg);
        item_t it;
        int    hi;
        it.vld = vld;
        it.per = per;
        it.lk  = lk;
        it.avg = avg;
        exp_q.push_back(it);
        if (lostd > 0) lost_q.push_back(lostd);
        hi = (gap < 200) ? gap / 2 : 50;
        mon_in = 1'b1;
        repeat (hi) @(negedge clk_in);
        mon_in = 1'b0;
        repeat (gap - hi) @(negedge clk_in);
    endtask

    // Edge monitor: compare each edge_stb against the scoreboard.
    initial begin
        item_t it;
        forever begin
            @(negedge clk_in);
            if (edge_stb === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_edge_stb: got edge_stb with no expected item");
                end else begin
                    it = exp_q.pop_front();
                    check("period_vld", {31'd0, period_vld}, {31'd0, it.vld});
                    if (it.vld) check("period_out", {22'd0, period_out}, it.per);
                    @(negedge clk_in);
                    check("locked", {31'd0, locked}, {31'd0, it.lk});
`ifdef SLOW_CLK_MON_AVG_EN
                    if (it.avg >= 0) check("period_avg", {22'd0, period_avg}, it.avg);
`else
                    if (it.vld) check("period_avg", {22'd0, period_avg}, it.per);
`endif
                end
            end
        end
    end

    // Lost monitor: lost_stb must arrive the queued number of cycles after edge_stb.
    initial begin
        int since;
        since = 0;
        forever begin
            @(negedge clk_in);
            if (edge_stb === 1'b1) since = 0;
            else since++;
            if (lost_stb === 1'b1) begin
                if (lost_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_lost_stb: got lost_stb %0d cycles after edge, expected none", since);
                end else begin
                    check("lost_delay", since, lost_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        mon_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk_in);

        // Nominal 100-cycle clock from reset: lock on the 4th good period.
        ev(100, 1'b0,   0, 1'b0, 0, -1);
        ev(100, 1'b1, 100, 1'b0, 0, -1);
        ev(100, 1'b1, 100, 1'b0, 0, -1);
        ev(100, 1'b1, 100, 1'b0, 0, -1);
        ev( 97, 1'b1, 100, 1'b1, 0, -1);
        check("err_cnt_first_lock", {24'd0, err_cnt}, 32'd0);
        check("locked_first_lock",  {31'd0, locked},  32'd1);

        // Short 97-cycle period while locked.
        ev(100, 1'b1,  97, 1'b0, 1, -1);
        check("err_cnt_after_97", {24'd0, err_cnt}, 32'd1);
        ev(100, 1'b1, 100, 1'b0, 0, -1);
        ev(100, 1'b1, 100, 1'b0, 0, -1);
        ev(100, 1'b1, 100, 1'b0, 0, -1);

        // Relock, then stuck low past saturation: one timeout loss only.
        ev(1100, 1'b1, 100, 1'b1, 104, -1);
        check("err_cnt_after_stuck", {24'd0, err_cnt}, 32'd2);

        // Alternating 98/102 locks and holds.
        ev( 98, 1'b1, 1023, 1'b0, 0, -1);
        ev(102, 1'b1,   98, 1'b0, 0, -1);
        ev( 98, 1'b1,  102, 1'b0, 0, -1);
        ev(102, 1'b1,   98, 1'b0, 0, -1);
        ev( 98, 1'b1,  102, 1'b1, 0, -1);
        ev(103, 1'b1,   98, 1'b1, 0, -1);

        // 103-cycle periods: edge beats timeout, never locks.
        ev(103, 1'b1, 103, 1'b0, 1, -1);
        check("err_cnt_after_103", {24'd0, err_cnt}, 32'd3);
        ev(103, 1'b1, 103, 1'b0, 0, -1);
        ev(103, 1'b1, 103, 1'b0, 0, -1);
        ev(100, 1'b1, 103, 1'b0, 0, -1);

        // Back to 100 and lock again.
        ev(100, 1'b1, 100, 1'b0, 0, -1);
        ev(100, 1'b1, 100, 1'b0, 0, -1);
        ev(100, 1'b1, 100, 1'b0, 0, -1);
        ev(100, 1'b1, 100, 1'b1, 0, -1);

        // Reset mid-LOCKED clears everything at once.
        rst = 1'b1;
        #1;
        check_zero("midrst");
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        repeat (3) @(negedge clk_in);

        // First edge after reset has no period; average fills after 4 periods.
        ev(100, 1'b0,   0, 1'b0, 0, -1);
        ev(100, 1'b1, 100, 1'b0, 0,  0);
        ev(102, 1'b1, 100, 1'b0, 0,  0);
        ev( 98, 1'b1, 102, 1'b0, 0,  0);
        ev( 20, 1'b1,  98, 1'b1, 0, 100);

        repeat (20) @(negedge clk_in);
        check("exp_q_drained",  exp_q.size(),  32'd0);
        check("lost_q_drained", lost_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
